// File: rtl/pe_load_scheduler.sv
// Pass sequencer for the PE array: staggered per-row weight loads, then activation
// load, then compute, repeated for a programmable number of passes.
module pe_load_scheduler #(
  parameter int NUM_ROWS         = 3,
  parameter int KERNEL_SIZE      = 3,
  parameter int WGHT_LOAD_CYCLES = KERNEL_SIZE**2 + 3,
  parameter int PASS_BITWIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [PASS_BITWIDTH-1:0] num_passes,
  output logic [NUM_ROWS-1:0]      load_wght,
  output logic                     load_act,
  input  logic                     act_done,
  output logic                     pe_start,
  input  logic                     pe_done,
  output logic                     busy,
  output logic                     done,
  output logic [PASS_BITWIDTH-1:0] pass_idx
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W = $clog2(WGHT_LOAD_CYCLES);

  localparam logic [ROW_W-1:0]         LAST_ROW  = ROW_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0]         WAIT_INIT = CNT_W'(WGHT_LOAD_CYCLES - 1);
  localparam logic [PASS_BITWIDTH-1:0] PASS_ONE  = PASS_BITWIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, W_ISSUE, W_WAIT, A_ISSUE, A_WAIT, C_ISSUE, C_WAIT, NEXT, FINISH
  } state_t;

  state_t                     state, state_nxt;
  logic [ROW_W-1:0]           row, row_nxt;
  logic [CNT_W-1:0]           cnt, cnt_nxt;
  logic [PASS_BITWIDTH-1:0]   pass_nxt;
  logic [PASS_BITWIDTH-1:0]   passes, passes_nxt;

  // NOTE: reset is synchronous here, so it only appears inside the clocked branch,
  // never in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      row      <= '0;
      cnt      <= '0;
      pass_idx <= '0;
      passes   <= '0;
    end else begin
      state    <= state_nxt;
      row      <= row_nxt;
      cnt      <= cnt_nxt;
      pass_idx <= pass_nxt;
      passes   <= passes_nxt;
    end
  end

  // NOTE: every signal written below gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    row_nxt    = row;
    cnt_nxt    = cnt;
    pass_nxt   = pass_idx;
    passes_nxt = passes;
    unique case (state)
      IDLE: begin
        if (start) begin
          passes_nxt = (num_passes == '0) ? PASS_ONE : num_passes;
          pass_nxt   = '0;
          row_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = W_ISSUE;
        end
      end
      W_ISSUE: begin
        cnt_nxt   = WAIT_INIT;
        state_nxt = W_WAIT;
      end
      W_WAIT: begin
        // The window closes when the decremented count reaches zero, so each row
        // occupies exactly WGHT_LOAD_CYCLES cycles including its pulse.
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          if (row == LAST_ROW) begin
            row_nxt   = '0;
            state_nxt = A_ISSUE;
          end else begin
            row_nxt   = row + ROW_W'(1);
            state_nxt = W_ISSUE;
          end
        end
      end
      A_ISSUE: state_nxt = A_WAIT;
      A_WAIT:  if (act_done) state_nxt = C_ISSUE;
      C_ISSUE: state_nxt = C_WAIT;
      C_WAIT:  if (pe_done) state_nxt = NEXT;
      NEXT: begin
        if (pass_idx == passes - PASS_ONE) begin
          state_nxt = FINISH;
        end else begin
          pass_nxt  = pass_idx + PASS_ONE;
          state_nxt = W_ISSUE;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pulses are pure state decodes, so they can never overlap and never see inputs.
  assign load_wght = (state == W_ISSUE) ? (NUM_ROWS'(1) << row) : '0;
  assign load_act  = (state == A_ISSUE);
  assign pe_start  = (state == C_ISSUE);
  assign done      = (state == FINISH);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pe_load_scheduler.sv
// Directed bench for pe_load_scheduler: default 3-row instance plus a 1-row, 5x5-kernel instance.
module tb_pe_load_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start0, act_done0, pe_done0;
  logic [7:0] num_passes0;
  logic [2:0] load_wght0;
  logic       load_act0, pe_start0, busy0, done0;
  logic [7:0] pass_idx0;

  logic       start1, act_done1, pe_done1;
  logic [7:0] num_passes1;
  logic [0:0] load_wght1;
  logic       load_act1, pe_start1, busy1, done1;
  logic [7:0] pass_idx1;

  int vectors = 0;
  int miscompares = 0;

  pe_load_scheduler u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .num_passes(num_passes0),
    .load_wght(load_wght0), .load_act(load_act0), .act_done(act_done0),
    .pe_start(pe_start0), .pe_done(pe_done0), .busy(busy0), .done(done0),
    .pass_idx(pass_idx0)
  );

  pe_load_scheduler #(.NUM_ROWS(1), .KERNEL_SIZE(5)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .num_passes(num_passes1),
    .load_wght(load_wght1), .load_act(load_act1), .act_done(act_done1),
    .pe_start(pe_start1), .pe_done(pe_done1), .busy(busy1), .done(done1),
    .pass_idx(pass_idx1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed as {load_wght, load_act, pe_start, done, busy, pass_idx}.
  task automatic check0(input string tag, input int c, input logic [2:0] lw, input logic la,
                        input logic ps, input logic dn, input logic bz, input logic [7:0] pi);
    logic [14:0] obs, exp;
    obs = {load_wght0, load_act0, pe_start0, done0, busy0, pass_idx0};
    exp = {lw, la, ps, dn, bz, pi};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input int c, input logic lw, input logic la,
                        input logic ps, input logic dn, input logic bz, input logic [7:0] pi);
    logic [12:0] obs, exp;
    obs = {load_wght1, load_act1, pe_start1, done1, busy1, pass_idx1};
    exp = {lw, la, ps, dn, bz, pi};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, c, obs, exp);
    end
  endtask

  // One pass on the default instance is 47 cycles: weights at 1/13/25, load_act 37,
  // act_done driven at 40, pe_start 41, pe_done driven at 46, NEXT 47, FINISH 48.
  task automatic run_trace(input string tag, input logic [7:0] np, input int passes,
                           input bit spurious, input int stop_c);
    int last, p, r;
    logic [2:0] lw;
    start0      = 1'b1;
    num_passes0 = np;
    last = 47 * (passes - 1) + 49;
    if (stop_c > 0) last = stop_c;
    for (int c = 1; c <= last; c++) begin
      tick();
      p = (c - 1) / 47;
      if (p > passes - 1) p = passes - 1;
      r = c - 47 * p;
      start0    = 1'b0;
      act_done0 = (r == 40);
      pe_done0  = (r == 46);
      if (spurious) begin
        if ((r >= 2 && r <= 12) || (r >= 14 && r <= 24) || (r >= 26 && r <= 36)) begin
          act_done0 = 1'b1;
          pe_done0  = 1'b1;
        end
        if (r == 37) act_done0 = 1'b1;
        if (r >= 37 && r <= 41) pe_done0 = 1'b1;
        if (r == 5 || r == 38 || r == 44) begin
          start0      = 1'b1;
          num_passes0 = 8'd7;
        end
      end
      lw = (r == 1) ? 3'b001 : (r == 13) ? 3'b010 : (r == 25) ? 3'b100 : 3'b000;
      check0(tag, c, lw, r == 37, r == 41, (p == passes - 1) && (r == 48),
             c <= 47 * (passes - 1) + 48, 8'(p));
    end
    start0    = 1'b0;
    act_done0 = 1'b0;
    pe_done0  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start0 = 1'b0; act_done0 = 1'b0; pe_done0 = 1'b0; num_passes0 = 8'd0;
    start1 = 1'b0; act_done1 = 1'b0; pe_done1 = 1'b0; num_passes1 = 8'd0;

    // Reset state, with start held high to show it is ignored under reset.
    tick();
    start0 = 1'b1;
    tick();
    check0("reset0", 0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    check1("reset1", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    start0 = 1'b0;
    reset  = 1'b0;
    tick();
    check0("idle0", 0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    run_trace("single_pass", 8'd1, 1, 1'b0, 0);
    run_trace("three_passes", 8'd3, 3, 1'b0, 0);
    run_trace("zero_passes", 8'd0, 1, 1'b0, 0);
    run_trace("spurious", 8'd1, 1, 1'b1, 0);

    // Stop at cycle 63 (pass 1, W_WAIT of row 1), then reset for one cycle.
    run_trace("pre_reset", 8'd3, 3, 1'b0, 63);
    reset = 1'b1;
    tick();
    check0("mid_reset", 64, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b0;
    tick();
    check0("post_reset_idle", 65, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    run_trace("restart", 8'd1, 1, 1'b0, 0);

    // One row, 28-cycle window: weight 1, load_act 29, act_done at first A_WAIT cycle 30,
    // pe_start 31, pe_done 32, NEXT 33, FINISH 34.
    start1      = 1'b1;
    num_passes1 = 8'd1;
    for (int c = 1; c <= 35; c++) begin
      tick();
      start1    = 1'b0;
      act_done1 = (c == 30);
      pe_done1  = (c == 32);
      check1("sweep", c, c == 1, c == 29, c == 31, c == 34, c <= 34, 8'd0);
    end
    act_done1 = 1'b0;
    pe_done1  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pe_load_scheduler.md
# pe_load_scheduler

Top-level sequencer for one processing pass of the PE array. On `start`, it pulses the per-row weight routers one at a time, spacing the pulses by a fixed load window. It then triggers the activation loader and waits for it to finish, then starts the PE array and waits for compute to complete. The whole sequence repeats for a programmable number of passes. It sits between the host/top control and the router/PE layer, and is the only source of `load_spad_ctrl` for the weight routers.

## Interface
- `NUM_ROWS`, 3: number of weight routers (PE rows), min 1, max 16
- `KERNEL_SIZE`, 3: filter width; one router loads `KERNEL_SIZE**2` words
- `WGHT_LOAD_CYCLES`, `KERNEL_SIZE**2+3`: cycles reserved per router load, measured from the pulse cycle; min 2
- `PASS_BITWIDTH`, 8: width of the pass counter

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock clk
- `start`  in  1  begin sequence; sampled only in IDLE
- `num_passes`  in  PASS_BITWIDTH  passes to run; latched on accepted `start`; 0 is treated as 1
- `load_wght`  out  NUM_ROWS  one-hot, one-cycle pulse to router r's `load_spad_ctrl`
- `load_act`  out  1  one-cycle pulse to the activation loader
- `act_done`  in  1  activation loader finished (level or pulse)
- `pe_start`  out  1  one-cycle pulse to the PE array
- `pe_done`  in  1  PE compute finished (level or pulse)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the final pass
- `pass_idx`  out  PASS_BITWIDTH  index of the current pass, 0-based

## Operation
- States: IDLE, W_ISSUE, W_WAIT, A_ISSUE, A_WAIT, C_ISSUE, C_WAIT, NEXT, FINISH.
- **IDLE**
  - On `start`: latch `num_passes` (0 becomes 1), clear `pass_idx` and the row counter, go to W_ISSUE.
  - Without `start`: stay in IDLE.
- **W_ISSUE**
  - Assert `load_wght[row]` for exactly this cycle.
  - Load the wait counter with `WGHT_LOAD_CYCLES-1`, go to W_WAIT.
- **W_WAIT**
  - Decrement the wait counter.
  - At 0: if `row == NUM_ROWS-1`, clear `row` and go to A_ISSUE; otherwise increment `row` and go to W_ISSUE.
  - Rows are never overlapped, because the routers share the GLB weight port.
- **A_ISSUE**: pulse `load_act`, go to A_WAIT.
- **A_WAIT**: stay until `act_done` is sampled high; then go to C_ISSUE.
  - `act_done` is ignored in every other state.
  - `act_done` already high in the A_ISSUE cycle is not consumed.
- **C_ISSUE**: pulse `pe_start`, go to C_WAIT.
- **C_WAIT**: same rule as A_WAIT, applied to `pe_done`; then go to NEXT.
- **NEXT**
  - If `pass_idx == passes_latched-1`, go to FINISH.
  - Otherwise increment `pass_idx` and go to W_ISSUE; weights are reloaded every pass.
- **FINISH**: pulse `done`, go to IDLE. `pass_idx` holds its last value until the next accepted `start`.
- `start` is ignored while `busy` is high; there is no queueing.
- At most one of `load_wght`, `load_act`, `pe_start`, `done` is high in any cycle.

## Timing
- All outputs are registered or decoded directly from state. They have no combinational path from inputs.
- Reset values:
  - `load_wght = 0`, `load_act = 0`, `pe_start = 0`, `busy = 0`, `done = 0`, `pass_idx = 0`
  - state = IDLE, and all counters = 0.
- Reset asserted in any state returns to IDLE on the next edge, with no pulse emitted in that cycle.
- Sequence timing, with `start` sampled at edge 0:
  - `load_wght[0]` is high in cycle 1.
  - `load_wght[r]` is high in cycle `1 + r*WGHT_LOAD_CYCLES`.
  - `load_act` is high in cycle `1 + NUM_ROWS*WGHT_LOAD_CYCLES`.
- Wait states:
  - `act_done` high in cycle t of A_WAIT produces `pe_start` in cycle t+1.
  - `pe_done` in cycle t of C_WAIT produces NEXT in t+1.
  - In the final pass, `done` follows in t+2; otherwise the next `load_wght[0]` follows in t+2.
- `busy` rises in the cycle after `start` is accepted and falls in the cycle after the `done` pulse.

## Test plan
- **Defaults, single pass.**
  - Stimulus: `num_passes=1`; `act_done` 3 cycles after `load_act`; `pe_done` 5 cycles after `pe_start`.
  - Required: `load_wght` = 001, 010, 100 at cycles 1, 13, 25; `load_act` at cycle 37; `pe_start` at 41; `done` at 48; no other pulses.
- **Three passes.**
  - Stimulus: `num_passes=3`.
  - Required: the weight triple is repeated for each pass; `pass_idx` steps 0→1→2; exactly one `done`; `busy` is continuous throughout.
- **Zero passes.**
  - Stimulus: `num_passes=0`.
  - Required: identical to the `num_passes=1` trace.
- **Spurious handshakes.**
  - Stimulus: hold `act_done=1` and `pe_done=1` throughout W_WAIT, and assert `start` while busy.
  - Required: no early advance, no restart; `act_done=1` exactly at the A_ISSUE cycle does not skip A_WAIT.
- **Reset mid-run.**
  - Stimulus: assert `reset` in W_WAIT of row 1 for one cycle.
  - Required: all outputs 0 the next cycle; a new `start` restarts from row 0 with `pass_idx=0`.
- **Parameter sweep.**
  - Stimulus: `NUM_ROWS=1`, `KERNEL_SIZE=5` (`WGHT_LOAD_CYCLES=28`).
  - Required: a single `load_wght` pulse; `load_act` exactly 28 cycles later.
